// File: rtl/gcm_pkg.sv
// Shared AES-GCM datapath definitions: block width and the fixed-width sideband payload.
package gcm_pkg;

  localparam int unsigned GCM_BLOCK_W = 128;

  typedef struct packed {
    logic                   valid;
    logic                   last;
    logic [GCM_BLOCK_W-1:0] keep;
    logic [GCM_BLOCK_W-1:0] user;
    logic [GCM_BLOCK_W-1:0] text;
  } gcm_sideband_t;

endpackage

// File: rtl/gcm_sideband_stage.sv
// One register stage of the sideband delay line: shifts on enable, flush clears only the
// valid/last qualifiers, reset clears everything.
module gcm_sideband_stage
  import gcm_pkg::*;
#(
  parameter int unsigned TEXT_W = GCM_BLOCK_W,
  parameter int unsigned USER_W = GCM_BLOCK_W,
  parameter int unsigned KEEP_W = GCM_BLOCK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [TEXT_W-1:0] text_i,
  input  logic [USER_W-1:0] user_i,
  input  logic [KEEP_W-1:0] keep_i,
  output logic              valid_o,
  output logic              last_o,
  output logic [TEXT_W-1:0] text_o,
  output logic [USER_W-1:0] user_o,
  output logic [KEEP_W-1:0] keep_o
);

  logic              valid_q, valid_d;
  logic              last_q,  last_d;
  logic [TEXT_W-1:0] text_q,  text_d;
  logic [USER_W-1:0] user_q,  user_d;
  logic [KEEP_W-1:0] keep_q,  keep_d;

  // A bubble never carries an end-of-frame marker; payload loads regardless of valid.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    text_d  = text_q;
    user_d  = user_q;
    keep_d  = keep_q;
    if (flush_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (en_i) begin
      valid_d = valid_i;
      last_d  = valid_i & last_i;
      text_d  = text_i;
      user_d  = user_i;
      keep_d  = keep_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      text_q  <= '0;
      user_q  <= '0;
      keep_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      text_q  <= text_d;
      user_q  <= user_d;
      keep_q  <= keep_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign text_o  = text_q;
  assign user_o  = user_q;
  assign keep_o  = keep_q;

endmodule

// File: rtl/gcm_sideband_delay.sv
// Stallable sideband delay line matched to the AES round pipeline, with in-flight beat and
// frame counters for the GCM controller.
module gcm_sideband_delay
  import gcm_pkg::*;
#(
  parameter int unsigned DEPTH  = 15,
  parameter int unsigned TEXT_W = GCM_BLOCK_W,
  parameter int unsigned USER_W = GCM_BLOCK_W,
  parameter int unsigned KEEP_W = GCM_BLOCK_W,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [TEXT_W-1:0] i_text,
  input  logic [USER_W-1:0] i_tuser,
  input  logic [KEEP_W-1:0] i_tkeep,
  input  logic              i_tlast,
  output logic              o_valid,
  output logic [TEXT_W-1:0] o_text,
  output logic [USER_W-1:0] o_tuser,
  output logic [KEEP_W-1:0] o_tkeep,
  output logic              o_tlast,
  output logic [CNT_W-1:0]  o_occupancy,
  output logic [CNT_W-1:0]  o_frames,
  output logic              o_empty
);

  localparam int unsigned LAST = DEPTH - 1;

  logic              st_valid [DEPTH];
  logic              st_last  [DEPTH];
  logic [TEXT_W-1:0] st_text  [DEPTH];
  logic [USER_W-1:0] st_user  [DEPTH];
  logic [KEEP_W-1:0] st_keep  [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              in_valid;
    logic              in_last;
    logic [TEXT_W-1:0] in_text;
    logic [USER_W-1:0] in_user;
    logic [KEEP_W-1:0] in_keep;

    if (k == 0) begin : g_head
      assign in_valid = i_valid;
      assign in_last  = i_tlast;
      assign in_text  = i_text;
      assign in_user  = i_tuser;
      assign in_keep  = i_tkeep;
    end else begin : g_body
      assign in_valid = st_valid[k-1];
      assign in_last  = st_last[k-1];
      assign in_text  = st_text[k-1];
      assign in_user  = st_user[k-1];
      assign in_keep  = st_keep[k-1];
    end

    gcm_sideband_stage #(
      .TEXT_W (TEXT_W),
      .USER_W (USER_W),
      .KEEP_W (KEEP_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en_i    (i_advance),
      .flush_i (i_flush),
      .valid_i (in_valid),
      .last_i  (in_last),
      .text_i  (in_text),
      .user_i  (in_user),
      .keep_i  (in_keep),
      .valid_o (st_valid[k]),
      .last_o  (st_last[k]),
      .text_o  (st_text[k]),
      .user_o  (st_user[k]),
      .keep_o  (st_keep[k])
    );
  end

  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] frm_q, frm_d;
  logic             empty_q, empty_d;

  // Counters track entry minus retirement; both are bounded by DEPTH so never wrap.
  always_comb begin
    occ_d   = occ_q;
    frm_d   = frm_q;
    empty_d = empty_q;
    if (i_flush) begin
      occ_d   = '0;
      frm_d   = '0;
      empty_d = 1'b1;
    end else if (i_advance) begin
      occ_d   = occ_q + CNT_W'(i_valid) - CNT_W'(st_valid[LAST]);
      frm_d   = frm_q + CNT_W'(i_valid & i_tlast)
                      - CNT_W'(st_valid[LAST] & st_last[LAST]);
      empty_d = (occ_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      frm_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      occ_q   <= occ_d;
      frm_q   <= frm_d;
      empty_q <= empty_d;
    end
  end

  assign o_valid     = st_valid[LAST];
  assign o_tlast     = st_last[LAST];
  assign o_text      = st_text[LAST];
  assign o_tuser     = st_user[LAST];
  assign o_tkeep     = st_keep[LAST];
  assign o_occupancy = occ_q;
  assign o_frames    = frm_q;
  assign o_empty     = empty_q;

endmodule

// File: tb/tb_gcm_sideband_delay.sv
// Bench for gcm_sideband_delay: three instances (DEPTH 15, 1, 16/narrow) share one stimulus
// and are compared each cycle against a tagged list of accepted beats.
module tb_gcm_sideband_delay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, adv, flush, valid, tlast;
  logic [127:0] text, tuser, tkeep;

  logic         v0, l0, e0;
  logic [127:0] t0, u0, k0;
  logic [3:0]   oc0, fr0;

  logic         v1, l1, e1;
  logic [127:0] t1, u1, k1;
  logic [0:0]   oc1, fr1;

  logic         v2, l2, e2;
  logic [63:0]  t2;
  logic [127:0] u2;
  logic [7:0]   k2;
  logic [4:0]   oc2, fr2;

  gcm_sideband_delay u_dut0 (
    .clk(clk), .rst(rst), .i_advance(adv), .i_flush(flush), .i_valid(valid),
    .i_text(text), .i_tuser(tuser), .i_tkeep(tkeep), .i_tlast(tlast),
    .o_valid(v0), .o_text(t0), .o_tuser(u0), .o_tkeep(k0), .o_tlast(l0),
    .o_occupancy(oc0), .o_frames(fr0), .o_empty(e0)
  );

  gcm_sideband_delay #(.DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_advance(adv), .i_flush(flush), .i_valid(valid),
    .i_text(text), .i_tuser(tuser), .i_tkeep(tkeep), .i_tlast(tlast),
    .o_valid(v1), .o_text(t1), .o_tuser(u1), .o_tkeep(k1), .o_tlast(l1),
    .o_occupancy(oc1), .o_frames(fr1), .o_empty(e1)
  );

  gcm_sideband_delay #(.DEPTH(16), .TEXT_W(64), .KEEP_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .i_advance(adv), .i_flush(flush), .i_valid(valid),
    .i_text(text[63:0]), .i_tuser(tuser), .i_tkeep(tkeep[7:0]), .i_tlast(tlast),
    .o_valid(v2), .o_text(t2), .o_tuser(u2), .o_tkeep(k2), .o_tlast(l2),
    .o_occupancy(oc2), .o_frames(fr2), .o_empty(e2)
  );

  typedef struct {
    int unsigned  tag;
    logic [127:0] text;
    logic [127:0] user;
    logic [127:0] keep;
    logic         last;
  } beat_t;

  beat_t        mq[$];
  int unsigned  acnt;
  int unsigned  cyc;
  int           n_tests;
  int           n_fail;
  logic [127:0] seen_t[$];
  int unsigned  seen_c[$];
  int unsigned  pk0, pk2, mf0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A beat accepted on advancing edge number `tag` sits in stage (acnt - tag).
  task automatic check_all();
    int unsigned  dep, eocc, efrm, gocc, gfrm;
    logic         ev, el, gv, gl, ge;
    logic [127:0] et, eu, ek, gt, gu, gk;
    for (int d = 0; d < 3; d++) begin
      dep = (d == 0) ? 15 : (d == 1) ? 1 : 16;
      ev = 1'b0; el = 1'b0; et = '0; eu = '0; ek = '0; eocc = 0; efrm = 0;
      foreach (mq[i]) begin
        if (acnt - mq[i].tag <= dep - 1) begin
          eocc++;
          if (mq[i].last) efrm++;
          if (acnt - mq[i].tag == dep - 1) begin
            ev = 1'b1; el = mq[i].last; et = mq[i].text; eu = mq[i].user; ek = mq[i].keep;
          end
        end
      end
      case (d)
        0:       begin gv = v0; gl = l0; ge = e0; gt = t0; gu = u0; gk = k0;
                       gocc = 32'(oc0); gfrm = 32'(fr0); end
        1:       begin gv = v1; gl = l1; ge = e1; gt = t1; gu = u1; gk = k1;
                       gocc = 32'(oc1); gfrm = 32'(fr1); end
        default: begin gv = v2; gl = l2; ge = e2; gt = 128'(t2); gu = u2; gk = 128'(k2);
                       gocc = 32'(oc2); gfrm = 32'(fr2);
                       et = {64'b0, et[63:0]}; ek = {120'b0, ek[7:0]}; end
      endcase
      check($sformatf("d%0d_valid", d), 128'(gv), 128'(ev));
      check($sformatf("d%0d_tlast", d), 128'(gl), 128'(el));
      check($sformatf("d%0d_occ", d), 128'(gocc), 128'(eocc));
      check($sformatf("d%0d_frames", d), 128'(gfrm), 128'(efrm));
      check($sformatf("d%0d_empty", d), 128'(ge), 128'(eocc == 0));
      if (ev) begin
        check($sformatf("d%0d_text", d), gt, et);
        check($sformatf("d%0d_tuser", d), gu, eu);
        check($sformatf("d%0d_tkeep", d), gk, ek);
      end
    end
  endtask

  task automatic step();
    beat_t b;
    @(posedge clk);
    cyc++;
    if (rst || flush) begin
      mq.delete();
    end else if (adv) begin
      acnt++;
      if (valid) begin
        b.tag = acnt; b.text = text; b.user = tuser; b.keep = tkeep; b.last = tlast;
        mq.push_back(b);
      end
      while (mq.size() > 0 && acnt - mq[0].tag >= 16) void'(mq.pop_front());
    end
    @(negedge clk);
    check_all();
    if (v0) begin
      seen_t.push_back(t0);
      seen_c.push_back(cyc);
    end
    if (32'(oc0) > pk0) pk0 = 32'(oc0);
    if (32'(oc2) > pk2) pk2 = 32'(oc2);
    if (32'(fr0) > mf0) mf0 = 32'(fr0);
  endtask

  task automatic drive(input logic v, input logic last, input logic a, input logic f);
    valid = v; tlast = last; adv = a; flush = f;
    text  = {$urandom, $urandom, $urandom, $urandom};
    tuser = {$urandom, $urandom, $urandom, $urandom};
    tkeep = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain(input int n);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (n) step();
  endtask

  localparam logic [127:0] KPAT = 128'h0123456789ABCDEF0123456789ABCDEF;

  initial begin
    logic [127:0] ta, tb, tc;
    int unsigned  acc_b, lat;
    logic         found;

    n_tests = 0; n_fail = 0; acnt = 0; cyc = 0; pk0 = 0; pk2 = 0; mf0 = 0;

    // Reset with random inputs.
    rst = 1'b1;
    repeat (2) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    check("rst_text", t0, '0);
    check("rst_tuser", u0, '0);
    check("rst_tkeep", k0, '0);
    check("rst_text_d2", 128'(t2), '0);
    check("rst_empty", 128'(e0 & e1 & e2), 128'(1));
    rst = 1'b0;

    // Single-beat latency on the default depth.
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(i == 1, 1'b0, 1'b1, 1'b0);
      if (i == 1) text = KPAT;
      step();
      if (!found && v0) begin
        found = 1'b1; lat = i;
        check("lat_text", t0, KPAT);
      end
    end
    check("lat_cycles", 128'(lat), 128'(15));
    drain(4);

    // Stall: A, B back to back, 5 stalled cycles with C presented, then C accepted.
    seen_t.delete(); seen_c.delete(); pk0 = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0); ta = text; step();
    drive(1'b1, 1'b0, 1'b1, 1'b0); tb = text; step(); acc_b = cyc;
    drive(1'b1, 1'b0, 1'b0, 1'b0); tc = text;
    repeat (5) step();
    adv = 1'b1; step();
    drain(25);
    check("stall_count", 128'(seen_t.size()), 128'(3));
    if (seen_t.size() == 3) begin
      check("stall_order_a", seen_t[0], ta);
      check("stall_order_b", seen_t[1], tb);
      check("stall_order_c", seen_t[2], tc);
      check("stall_lat_b", 128'(seen_c[1] - acc_b + 1), 128'(20));
      check("stall_lat_c", 128'(seen_c[2] - (acc_b + 1) + 1), 128'(20));
    end
    check("stall_peak_occ", 128'(pk0), 128'(3));

    // Four-beat frames.
    mf0 = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, (i % 4) == 3, 1'b1, 1'b0);
      step();
    end
    drain(20);
    check("frames_max_le4", 128'(mf0 <= 4), 128'(1));
    check("frames_drained", 128'(fr0), 128'(0));
    check("frames_drained_d2", 128'(fr2), 128'(0));

    // Flush with a coincident input beat.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom), 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    check("flush_occ", 128'(oc0), 128'(0));
    check("flush_frames", 128'(fr0), 128'(0));
    check("flush_empty", 128'(e0), 128'(1));
    seen_t.delete(); seen_c.delete();
    drain(15);
    check("flush_no_valid", 128'(seen_t.size()), 128'(0));

    // Continuous input fills every depth exactly.
    pk2 = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'($urandom), 1'b1, 1'b0);
      step();
    end
    check("full_occ_d0", 128'(oc0), 128'(15));
    check("full_occ_d1", 128'(oc1), 128'(1));
    check("full_occ_d2", 128'(oc2), 128'(16));
    check("full_peak_d2", 128'(pk2), 128'(16));
    drain(20);

    // Random traffic with stalls, flushes and occasional reset.
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    drain(20);
    check("end_empty", 128'(e0 & e1 & e2), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcm_sideband_delay.md
# gcm_sideband_delay

Parametrised, stallable delay line that carries the per-block sideband of the AES-GCM datapath (text, AAD/tuser, tkeep, tlast) alongside the AES round pipeline so it emerges aligned with the keystream. It generalises the fixed 15-stage, always-advancing bypass chain with configurable depth and widths, a per-stage valid bit, a shared advance (stall) enable, a flush, and in-flight occupancy and frame counters for the GCM controller.

## Interface
Parameters:
- DEPTH, 15, number of register stages; must be ≥1; must equal the AES core pipeline depth.
- TEXT_W, 128, text width.
- USER_W, 128, tuser/AAD width.
- KEEP_W, 128, tkeep width.
- CNT_W, $clog2(DEPTH+1), counter width (derived; do not override).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_advance  in  1  pipeline enable, shared with the AES core; 0 freezes every stage.
- i_flush  in  1  synchronous clear of all valid bits and counters.
- i_valid  in  1  input beat valid.
- i_text  in  TEXT_W  input text.
- i_tuser  in  USER_W  input AAD/tuser.
- i_tkeep  in  KEEP_W  input byte keep.
- i_tlast  in  1  input end-of-frame.
- o_valid  out  1  output beat valid.
- o_text  out  TEXT_W  delayed text.
- o_tuser  out  USER_W  delayed tuser.
- o_tkeep  out  KEEP_W  delayed tkeep.
- o_tlast  out  1  delayed tlast, qualified by o_valid.
- o_occupancy  out  CNT_W  number of valid stages.
- o_frames  out  CNT_W  number of valid stages holding tlast=1.
- o_empty  out  1  o_occupancy==0.

## Operation
- Stage k (0..DEPTH-1) holds {valid, text, tuser, tkeep, last}. Stage 0 loads from the inputs; stage k loads from stage k-1; outputs are driven directly from stage DEPTH-1.
- i_advance=1: all stages shift one position at once. The beat in the last stage is retired (presented on o_* in that cycle, gone on the next).
- i_advance=0: every stage holds; input is ignored (the caller must hold i_valid low or re-present the beat).
- A stage loaded with valid=0 stores last=0 regardless of i_tlast; data fields load unconditionally.
- Counters, updated only when i_advance=1: occupancy += (i_valid) − (stage DEPTH-1 valid); frames += (i_valid & i_tlast) − (last-stage valid & last). Both are saturation-free by construction (bounded by DEPTH).
- Priority per cycle: rst > i_flush > i_advance. A flush clears every valid bit, last bit, occupancy and frames; data fields are left untouched; the input beat of that cycle is dropped.
- rst mid-stream: identical to a flush, and additionally zeroes all data fields.

## Timing
- Latency: a beat accepted on the edge where i_advance=1 appears on o_* after exactly DEPTH advancing edges. Stalled cycles add no latency.
- Throughput: one beat per advancing cycle.
- Reset values: o_valid=0, o_text=0, o_tuser=0, o_tkeep=0, o_tlast=0, o_occupancy=0, o_frames=0, o_empty=1.
- o_occupancy/o_frames/o_empty are registered and reflect stage contents after the same edge; there is no combinational path from i_* to any o_*.
- DEPTH=1: single register stage; counters range 0..1.
- Simultaneous entry and exit on an advancing edge leaves occupancy unchanged.

## Structure
- Shared package gcm_pkg: GCM_BLOCK_W=128 constant (default for TEXT_W/USER_W/KEEP_W) and typedef gcm_sideband_t packed struct {valid, last, keep, user, text} for fixed-width instances.
- One sub-module: gcm_sideband_stage (a single enable/flush register stage), instantiated DEPTH times with a generate loop; the counters live in the top module.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → all outputs zero, o_empty=1; after release, i_valid=1, i_text=0x0123…EF, i_advance=1 continuous → o_text=0x0123…EF with o_valid=1 exactly 15 cycles later.
- Stall: send beats A,B,C back-to-back, hold i_advance=0 for 5 cycles after B enters → outputs appear in order A,B,C with total latency 15+5 cycles for B and C; o_occupancy peaks at 3.
- Frames: stream 4-beat frames with tlast on every 4th beat for 40 cycles → o_frames never exceeds 4, returns to 0 after the final drain, o_tlast aligned with every 4th o_valid.
- Flush: fill 10 beats, pulse i_flush together with i_advance=1 and i_valid=1 → next cycle o_occupancy=0, o_frames=0, o_empty=1, no o_valid for the following 15 cycles.
- Parameter sweep: DEPTH=1 and DEPTH=16 with TEXT_W=64, KEEP_W=8 → latency equals DEPTH, occupancy reaches DEPTH under continuous input and does not exceed it.
